// File: rtl/alu_pkg.sv
// Shared definitions for the R-type ALU execute unit: MIPS funct codes,
// control state encoding and a legality check on the funct field.
package alu_pkg;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   function automatic logic isLegalFunct(input logic [5:0] f);
      case (f)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT,
         FN_MULTU, FN_MFHI, FN_MFLO: isLegalFunct = 1'b1;
         default:                    isLegalFunct = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. One partial-product step per
// cycle for WIDTH cycles. The accumulator starts as {0, multiplier}; each
// step conditionally adds the multiplicand into the upper half and shifts
// the whole thing right, so after WIDTH steps it holds the full product.
// 'done' is high during the final step cycle and 'product' shows the value
// the accumulator takes at the end of the current step, so the parent can
// capture the finished product on the same edge the multiplier retires.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     opA,
   input  logic [WIDTH-1:0]     opB,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     partial;
   logic [2*WIDTH-1:0] accNext;

   // one shift-add step: add multiplicand if the current low bit is set, then shift right
   always_comb begin
      addend  = acc[0] ? mcand : '0;
      partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      accNext = {partial, acc[WIDTH-1:1]};
      done    = busy && (cnt == CNT_W'(WIDTH - 1));
      product = accNext;
   end

   // operand latch, accumulator and iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         mcand <= opA;
         acc   <= {{WIDTH{1'b0}}, opB};
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         acc <= accNext;
         cnt <= cnt + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// MIPS R-type execute unit: single-cycle logic/arith/SLT/MFHI/MFLO plus an
// iterative MULTU writing HI/LO. Valid/ready handshake on both sides; the
// output register holds until consumed.
//
// state  | meaning
// S_IDLE | accepting requests whenever the output slot is free or draining
// S_MUL  | multiplier iterating; input side stalled until the product lands
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             illegal
);

   state_t state;
   state_t stateNext;

   logic                 inReadyInt;
   logic                 accept;
   logic                 isMultu;
   logic                 mulStart;
   logic                 mulBusy;
   logic                 mulDone;
   logic [2*WIDTH-1:0]   mulProduct;

   logic [WIDTH-1:0]     hiReg;
   logic [WIDTH-1:0]     loReg;
   logic [WIDTH-1:0]     resultReg;
   logic                 zeroReg;
   logic                 ovfReg;
   logic                 illegalReg;
   logic                 outValidReg;

   logic [WIDTH-1:0]     sumAB;
   logic [WIDTH-1:0]     diffAB;
   logic                 ovfAdd;
   logic                 ovfSub;
   logic [WIDTH-1:0]     opResult;
   logic                 opOvf;
   logic                 opIllegal;

   assign isMultu = (funct == FN_MULTU);

   alu_mul_iter #(.WIDTH(WIDTH)) uMul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mulStart),
      .opA     (src_a),
      .opB     (src_b),
      .busy    (mulBusy),
      .done    (mulDone),
      .product (mulProduct)
   );

   // single-cycle datapath; SLT uses diff sign corrected by overflow so it stays right when a-b wraps
   always_comb begin
      sumAB     = src_a + src_b;
      diffAB    = src_a - src_b;
      ovfAdd    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sumAB[WIDTH-1] != src_a[WIDTH-1]);
      ovfSub    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diffAB[WIDTH-1] != src_a[WIDTH-1]);
      opResult  = '0;
      opOvf     = 1'b0;
      opIllegal = !isLegalFunct(funct);
      case (funct)
         FN_AND:  opResult = src_a & src_b;
         FN_OR:   opResult = src_a | src_b;
         FN_NOR:  opResult = ~(src_a | src_b);
         FN_ADD: begin
            opResult = sumAB;
            opOvf    = ovfAdd;
         end
         FN_SUB: begin
            opResult = diffAB;
            opOvf    = ovfSub;
         end
         FN_SLT:  opResult = {{(WIDTH-1){1'b0}}, diffAB[WIDTH-1] ^ ovfSub};
         FN_MFHI: opResult = hiReg;
         FN_MFLO: opResult = loReg;
         default: opResult = '0;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // next-state: enter MUL on an accepted MULTU, leave on the final multiply step
   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE:  if (accept && isMultu) stateNext = S_MUL;
         S_MUL:   if (mulDone) stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   // handshake outputs: stall while multiplying or while a result is stuck downstream
   always_comb begin
      inReadyInt = (state == S_IDLE) && !mulBusy && (!outValidReg || out_ready);
      accept     = in_valid && inReadyInt;
      mulStart   = accept && isMultu;
   end

   // output register, flags and HI/LO; a new result may overwrite one being consumed this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resultReg   <= '0;
         zeroReg     <= 1'b0;
         ovfReg      <= 1'b0;
         illegalReg  <= 1'b0;
         outValidReg <= 1'b0;
         hiReg       <= '0;
         loReg       <= '0;
      end else if (accept && !isMultu) begin
         resultReg   <= opResult;
         zeroReg     <= (opResult == '0);
         ovfReg      <= opOvf;
         illegalReg  <= opIllegal;
         outValidReg <= 1'b1;
      end else if ((state == S_MUL) && mulDone) begin
         hiReg       <= mulProduct[2*WIDTH-1:WIDTH];
         loReg       <= mulProduct[WIDTH-1:0];
         resultReg   <= mulProduct[WIDTH-1:0];
         zeroReg     <= (mulProduct[WIDTH-1:0] == '0);
         ovfReg      <= 1'b0;
         illegalReg  <= 1'b0;
         outValidReg <= 1'b1;
      end else if (outValidReg && out_ready) begin
         outValidReg <= 1'b0;
      end
   end

   assign in_ready  = inReadyInt;
   assign out_valid = outValidReg;
   assign result    = resultReg;
   assign zero      = zeroReg;
   assign ovf       = ovfReg;
   assign illegal   = illegalReg;

endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
module tb_alu_multicycle;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   typedef struct packed {
      logic [5:0]  f;
      logic [31:0] r;
      logic        z;
      logic        o;
      logic        il;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  funct;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        ovf;
   logic        illegal;

   int          tests = 0;
   int          fails = 0;
   exp_t        q[$];
   logic [31:0] hiM;
   logic [31:0] loM;
   int          readyMode;
   logic        randBit;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct     (funct),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .ovf       (ovf),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign out_ready = (readyMode == 2) ? randBit : (readyMode == 1);

   always @(posedge clk) begin
      #1;
      randBit = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: computes the architectural result from the MIPS rules.
   task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint s;
      logic [63:0] p;
      e.f = f;
      e.r = '0;
      e.o = 1'b0;
      e.il = 1'b0;
      case (f)
         F_AND: e.r = a & b;
         F_OR:  e.r = a | b;
         F_NOR: e.r = ~(a | b);
         F_ADD: begin
            e.r = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            e.o = (s > MAXS) || (s < MINS);
         end
         F_SUB: begin
            e.r = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            e.o = (s > MAXS) || (s < MINS);
         end
         F_SLT: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         F_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            hiM = p[63:32];
            loM = p[31:0];
            e.r = loM;
         end
         F_MFHI: e.r = hiM;
         F_MFLO: e.r = loM;
         default: e.il = 1'b1;
      endcase
      e.z = (e.r == 32'd0);
      q.push_back(e);
   endtask

   task automatic stepSync;
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic got;
      got = 1'b0;
      in_valid = 1'b1;
      funct = f;
      src_a = a;
      src_b = b;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            model(f, a, b);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: funct %b never accepted", f);
      end
   endtask

   task automatic measure(input string name, input int expCycles, output logic rdyLow);
      int n;
      n = 0;
      rdyLow = 1'b1;
      for (int i = 1; i <= 100 && n == 0; i++) begin
         @(negedge clk);
         if (out_valid) n = i;
         else if (in_ready) rdyLow = 1'b0;
      end
      check(name, 64'(n), 64'(expCycles));
   endtask

   task automatic drain;
      for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // Monitor: every transfer on the output side must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: result %h with nothing pending", result);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (result !== e.r || zero !== e.z || ovf !== e.o || illegal !== e.il) begin
               fails++;
               $display("FAIL scoreboard funct=%b: got r=%h z=%b o=%b il=%b, expected r=%h z=%b o=%b il=%b",
                        e.f, result, zero, ovf, illegal, e.r, e.z, e.o, e.il);
            end
         end
      end
   end

   initial begin
      logic        rdyLow;
      logic [31:0] held;
      logic        okHold;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] edges [5];
      edges[0] = 32'h0000_0000;
      edges[1] = 32'h0000_0001;
      edges[2] = 32'h7FFF_FFFF;
      edges[3] = 32'h8000_0000;
      edges[4] = 32'hFFFF_FFFF;
      rst_n = 1'b0;
      in_valid = 1'b0;
      funct = '0;
      src_a = '0;
      src_b = '0;
      readyMode = 1;
      randBit = 1'b1;
      hiM = '0;
      loM = '0;

      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stepSync();

      issue(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      measure("add_latency", 1, rdyLow);
      stepSync();
      issue(F_SLT, 32'h8000_0000, 32'h0000_0001);
      issue(F_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
      drain();

      stepSync();
      issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      measure("multu_latency", 33, rdyLow);
      check("multu_in_ready_low", 64'(rdyLow), 64'd1);
      stepSync();
      issue(F_MFHI, 32'd0, 32'd0);
      issue(F_MFLO, 32'd0, 32'd0);
      drain();

      stepSync();
      readyMode = 0;
      issue(F_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      held = result;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         okHold = out_valid && !in_ready && (result == held);
         check("bp_hold", 64'(okHold), 64'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      funct = F_OR;
      src_a = 32'h0000_00F0;
      src_b = 32'h0000_000F;
      readyMode = 1;
      @(negedge clk);
      check("bp_release_ready", 64'(in_ready), 64'd1);
      if (in_ready) model(F_OR, 32'h0000_00F0, 32'h0000_000F);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_new_valid", 64'(out_valid), 64'd1);
      drain();

      stepSync();
      issue(F_MULTU, 32'd12345, 32'd6789);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      hiM = '0;
      loM = '0;
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      okHold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) okHold = 1'b0;
      end
      check("midrst_idle_after", 64'(okHold), 64'd1);
      stepSync();
      issue(F_MFLO, 32'd0, 32'd0);
      issue(F_MFHI, 32'd0, 32'd0);
      drain();

      stepSync();
      issue(6'b111111, 32'd5, 32'd3);
      issue(F_AND, 32'd5, 32'd3);
      drain();

      stepSync();
      readyMode = 2;
      for (int n = 0; n < 300; n++) begin
         int k;
         k = $urandom_range(0, 19);
         a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         case (k)
            0: f = F_MULTU;
            1: begin
               f = 6'($urandom);
               while (f == F_ADD || f == F_SUB || f == F_AND || f == F_OR || f == F_NOR ||
                      f == F_SLT || f == F_MULTU || f == F_MFHI || f == F_MFLO)
                  f = 6'($urandom);
            end
            2: f = F_MFHI;
            3: f = F_MFLO;
            4, 5, 6: f = F_ADD;
            7, 8, 9: f = F_SUB;
            10, 11, 12: f = F_SLT;
            13, 14: f = F_AND;
            15, 16: f = F_OR;
            default: f = F_NOR;
         endcase
         issue(f, a, b);
         repeat ($urandom_range(0, 2)) stepSync();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
